noise_detector: RTL and testbench
=================================

NOISE_DETECTOR -- requirements
Module: noise_detector

Interface
REQ-001 Parameter WINDOW_CYCLES, default 1000, SHALL set the measurement window length in clk cycles (legal: >=2).
REQ-002 Parameter CNT_W, default 10, SHALL set the edge-counter and debug_edge_count width.
REQ-003 Parameter MIN_EDGES, default 4, SHALL set the lower bound of the valid-noise edge band (inclusive).
REQ-004 Parameter MAX_EDGES, default 200, SHALL set the upper bound (inclusive); legal only when MIN_EDGES <= MAX_EDGES <= 2^CNT_W-1.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-007 enable  input  1  SHALL be the level request to run back-to-back measurement windows.
REQ-008 comp_in  input  1  SHALL be the asynchronous comparator output from the diode noise front end.
REQ-009 noise_valid  output  1  SHALL be the registered result of the last completed window, held until the next completed window.
REQ-010 window_done  output  1  SHALL be a one-cycle pulse marking a completed window.
REQ-011 busy  output  1  SHALL be high while a window is being measured.
REQ-012 debug_edge_count  output  CNT_W  SHALL be the edge count latched at the last completed window.

Function
REQ-013 comp_in SHALL pass through a 2-flop synchronizer; rising edges SHALL be detected against a previous-sample register that updates every cycle regardless of state.
REQ-014 FSM states IDLE, MEASURE, REPORT; IDLE -> MEASURE when enable=1, clearing window counter and edge counter.
REQ-015 In MEASURE the window counter SHALL count 0..WINDOW_CYCLES-1; at WINDOW_CYCLES-1 the next state SHALL be REPORT.
REQ-016 In MEASURE each detected rising edge SHALL increment the edge counter, saturating at 2^CNT_W-1; an edge on the last MEASURE cycle SHALL be counted.
REQ-017 Edges detected in IDLE or REPORT SHALL be ignored.
REQ-018 REPORT SHALL last one cycle: window_done=1, debug_edge_count=edge count, noise_valid=1 iff MIN_EDGES <= count <= MAX_EDGES.
REQ-019 From REPORT: enable=1 -> MEASURE with counters cleared (no gap cycle); enable=0 -> IDLE.
REQ-020 enable=0 in MEASURE SHALL abort to IDLE next cycle; no window_done; noise_valid and debug_edge_count unchanged.
REQ-021 busy SHALL be 1 exactly in MEASURE cycles.
REQ-022 Latency: enable sampled high in IDLE at cycle 0 SHALL give window_done at cycle WINDOW_CYCLES+1.
REQ-023 comp_in-to-count latency SHALL be 3 cycles (2 sync + 1 edge detect).

Reset
REQ-024 reset SHALL force IDLE, clear both counters, synchronizer, edge and filter registers, and drive noise_valid=0, window_done=0, busy=0, debug_edge_count=0 on the next edge.
REQ-025 reset SHALL take priority over enable and every in-flight window; a window interrupted by reset SHALL produce no window_done.

Configuration
REQ-026 With NOISE_DEBOUNCE_EN defined, a filter SHALL sit after the synchronizer whose output changes only after 3 consecutive equal synchronized samples, adding 2 cycles to REQ-023 latency (total 5).
REQ-027 Without NOISE_DEBOUNCE_EN, the synchronized signal SHALL feed the edge detector directly; no filter logic present.

Verification (WINDOW_CYCLES=64, CNT_W=4, MIN_EDGES=2, MAX_EDGES=5, macro off unless noted)
REQ-028 Reset held 3 cycles, comp_in toggling -> all outputs 0, state IDLE.
REQ-029 enable=1 at cycle 0, 3 pulses (4 high/4 low) mid-window -> window_done at cycle 65 only, debug_edge_count=3, noise_valid=1, busy low at 65, high again at 66.
REQ-030 enable=1, comp_in static 0 -> debug_edge_count=0, noise_valid=0 at cycle 65.
REQ-031 enable=1, 20 pulses (period 3) in window -> debug_edge_count=15 (saturated), noise_valid=0.
REQ-032 After a valid window, enable=0 at window cycle 30 -> busy=0 next cycle, no window_done, noise_valid stays 1; reset at MEASURE cycle 10 -> all outputs 0 next cycle.
REQ-033 NOISE_DEBOUNCE_EN defined, 1-cycle and 2-cycle glitches plus 2 clean 6-cycle pulses -> debug_edge_count=2.

Source files
------------

// File: rtl/noise_detector.sv
// Diode-noise health detector: counts synchronized comparator rising edges over a fixed window.
// Optional glitch filter enabled by defining NOISE_DEBOUNCE_EN.
module noise_detector #(
   parameter int WINDOW_CYCLES = 1000,
   parameter int CNT_W         = 10,
   parameter int MIN_EDGES     = 4,
   parameter int MAX_EDGES     = 200
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             comp_in,
   output logic             noise_valid,
   output logic             window_done,
   output logic             busy,
   output logic [CNT_W-1:0] debug_edge_count
);

   localparam int               WIN_W    = $clog2(WINDOW_CYCLES);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] MIN_L    = CNT_W'(MIN_EDGES);
   localparam logic [CNT_W-1:0] MAX_L    = CNT_W'(MAX_EDGES);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_MEASURE = 2'd1;
   localparam logic [1:0] ST_REPORT  = 2'd2;

   function automatic logic in_band(input logic [CNT_W-1:0] cnt);
      return (cnt >= MIN_L) && (cnt <= MAX_L);
   endfunction

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             prev_q, prev_d;
   logic             clean_s;
   logic             edge_s;
   logic [1:0]       state_q, state_d;
   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
   logic [CNT_W-1:0] cnt_plus_s;
   logic             noise_valid_q, noise_valid_d;
   logic             window_done_q, window_done_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] dbg_cnt_q, dbg_cnt_d;

`ifdef NOISE_DEBOUNCE_EN
   logic hist1_q, hist1_d;
   logic hist2_q, hist2_d;
   logic filt_q, filt_d;

   // Output follows the input only once three consecutive samples agree.
   always_comb begin
      hist1_d = sync2_q;
      hist2_d = hist1_q;
      if ((sync2_q == hist1_q) && (hist1_q == hist2_q)) begin
         clean_s = sync2_q;
      end else begin
         clean_s = filt_q;
      end
      filt_d = clean_s;
   end

   // Filter history registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         hist1_q <= 1'b0;
         hist2_q <= 1'b0;
         filt_q  <= 1'b0;
      end else begin
         hist1_q <= hist1_d;
         hist2_q <= hist2_d;
         filt_q  <= filt_d;
      end
   end
`else
   // Synchronized comparator feeds edge detection directly.
   always_comb begin
      clean_s = sync2_q;
   end
`endif

   // Synchronizer and rising-edge detect; the previous sample tracks every cycle.
   always_comb begin
      sync1_d    = comp_in;
      sync2_d    = sync1_q;
      prev_d     = clean_s;
      edge_s     = clean_s & ~prev_q;
      if (edge_s && (edge_cnt_q != CNT_MAX)) begin
         cnt_plus_s = edge_cnt_q + CNT_W'(1);
      end else begin
         cnt_plus_s = edge_cnt_q;
      end
   end

   // Window FSM; results are latched on the MEASURE->REPORT transition so they are registered.
   always_comb begin
      state_d       = state_q;
      win_cnt_d     = win_cnt_q;
      edge_cnt_d    = edge_cnt_q;
      noise_valid_d = noise_valid_q;
      window_done_d = 1'b0;
      dbg_cnt_d     = dbg_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d    = ST_MEASURE;
               win_cnt_d  = {WIN_W{1'b0}};
               edge_cnt_d = {CNT_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MEASURE: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (win_cnt_q == WIN_LAST) begin
               state_d       = ST_REPORT;
               edge_cnt_d    = cnt_plus_s;
               window_done_d = 1'b1;
               dbg_cnt_d     = cnt_plus_s;
               noise_valid_d = in_band(cnt_plus_s);
            end else begin
               win_cnt_d  = win_cnt_q + WIN_W'(1);
               edge_cnt_d = cnt_plus_s;
            end
         end
         ST_REPORT: begin
            if (enable) begin
               state_d    = ST_MEASURE;
               win_cnt_d  = {WIN_W{1'b0}};
               edge_cnt_d = {CNT_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_MEASURE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         prev_q        <= 1'b0;
         state_q       <= ST_IDLE;
         win_cnt_q     <= {WIN_W{1'b0}};
         edge_cnt_q    <= {CNT_W{1'b0}};
         noise_valid_q <= 1'b0;
         window_done_q <= 1'b0;
         busy_q        <= 1'b0;
         dbg_cnt_q     <= {CNT_W{1'b0}};
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         prev_q        <= prev_d;
         state_q       <= state_d;
         win_cnt_q     <= win_cnt_d;
         edge_cnt_q    <= edge_cnt_d;
         noise_valid_q <= noise_valid_d;
         window_done_q <= window_done_d;
         busy_q        <= busy_d;
         dbg_cnt_q     <= dbg_cnt_d;
      end
   end

   assign noise_valid      = noise_valid_q;
   assign window_done      = window_done_q;
   assign busy             = busy_q;
   assign debug_edge_count = dbg_cnt_q;

endmodule

// File: tb/tb_noise_detector.sv
// Directed bench for noise_detector (WINDOW_CYCLES=64, CNT_W=4, band 2..5).
// Define NOISE_DEBOUNCE_EN for both files to run the glitch-filter window instead of the saturation window.
module tb_noise_detector;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       comp_in;
   logic       noise_valid;
   logic       window_done;
   logic       busy;
   logic [3:0] debug_edge_count;

   int n_vec;
   int n_err;

   noise_detector #(
      .WINDOW_CYCLES(64),
      .CNT_W(4),
      .MIN_EDGES(2),
      .MAX_EDGES(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .comp_in(comp_in),
      .noise_valid(noise_valid),
      .window_done(window_done),
      .busy(busy),
      .debug_edge_count(debug_edge_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // mode 0: n pulses of hi/lo cycles starting at window cycle 4; mode 1: two glitches plus two clean pulses
   task automatic run_window(input int mode, input int n, input int hi, input int lo,
                             input logic [3:0] exp_cnt, input logic exp_nv, input string tag);
      int per;
      per = hi + lo;
      enable = 1'b1;
      tick();
      for (int c = 1; c <= 64; c++) begin
         if (mode == 0) begin
            comp_in = (c >= 4) && (c < 4 + n * per) && (((c - 4) % per) < hi);
         end else begin
            comp_in = (c == 5) || (c == 10) || (c == 11) ||
                      (c >= 20 && c < 26) || (c >= 35 && c < 41);
         end
         check({tag, "_busy"}, 16'(busy), 16'd1);
         check({tag, "_nodone"}, 16'(window_done), 16'd0);
         tick();
      end
      comp_in = 1'b0;
      check({tag, "_done"}, 16'(window_done), 16'd1);
      check({tag, "_count"}, 16'(debug_edge_count), 16'(exp_cnt));
      check({tag, "_valid"}, 16'(noise_valid), 16'(exp_nv));
      check({tag, "_busy_rep"}, 16'(busy), 16'd0);
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      reset   = 1'b1;
      enable  = 1'b1;
      comp_in = 1'b0;

      // reset held with enable high and comp_in toggling
      for (int i = 0; i < 3; i++) begin
         comp_in = ~comp_in;
         tick();
         check("rst_valid", 16'(noise_valid), 16'd0);
         check("rst_done", 16'(window_done), 16'd0);
         check("rst_busy", 16'(busy), 16'd0);
         check("rst_count", 16'(debug_edge_count), 16'd0);
      end
      reset   = 1'b0;
      enable  = 1'b0;
      comp_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("idle_busy", 16'(busy), 16'd0);
      end

      run_window(0, 3, 4, 4, 4'd3, 1'b1, "w3");
      run_window(0, 0, 4, 4, 4'd0, 1'b0, "w0");

      enable = 1'b0;
      tick();
      check("gap_busy", 16'(busy), 16'd0);
      check("gap_done", 16'(window_done), 16'd0);
      check("gap_hold", 16'(debug_edge_count), 16'd0);

`ifdef NOISE_DEBOUNCE_EN
      run_window(1, 0, 1, 1, 4'd2, 1'b1, "wglitch");
`else
      run_window(0, 20, 1, 2, 4'd15, 1'b0, "wsat");
`endif
      run_window(0, 5, 4, 4, 4'd5, 1'b1, "w5");
      run_window(0, 6, 4, 4, 4'd6, 1'b0, "w6");
      run_window(0, 1, 4, 4, 4'd1, 1'b0, "w1");
      run_window(0, 2, 4, 4, 4'd2, 1'b1, "w2");

      // abort at window cycle 30
      tick();
      for (int c = 1; c < 30; c++) begin
         tick();
      end
      check("abort_busy_pre", 16'(busy), 16'd1);
      enable = 1'b0;
      tick();
      check("abort_busy", 16'(busy), 16'd0);
      check("abort_done", 16'(window_done), 16'd0);
      check("abort_valid", 16'(noise_valid), 16'd1);
      check("abort_count", 16'(debug_edge_count), 16'd2);
      for (int i = 0; i < 70; i++) begin
         tick();
         check("abort_nodone", 16'(window_done), 16'd0);
      end
      check("abort_valid_hold", 16'(noise_valid), 16'd1);

      // reset at measure cycle 10
      enable = 1'b1;
      tick();
      check("rst2_busy_pre", 16'(busy), 16'd1);
      for (int c = 1; c < 10; c++) begin
         tick();
      end
      reset  = 1'b1;
      enable = 1'b0;
      tick();
      check("rst2_valid", 16'(noise_valid), 16'd0);
      check("rst2_done", 16'(window_done), 16'd0);
      check("rst2_busy", 16'(busy), 16'd0);
      check("rst2_count", 16'(debug_edge_count), 16'd0);
      reset = 1'b0;
      for (int i = 0; i < 70; i++) begin
         tick();
         check("rst2_nodone", 16'(window_done), 16'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
